// File: rtl/pdua_alu_seq_if.sv
// Operand/result bundle between the PDUA microcode sequencer and the ALU.
// Pure wiring: no latency; no registers in the interface itself.
// Backpressure: none; the ALU signals readiness through busy/done only.
interface pdua_alu_seq_if #(
    parameter int MAX_WIDTH = 8,
    parameter int SHAMT_W   = 2
);
    logic                 start;
    logic [2:0]           selop;
    logic [1:0]           shmode;
    logic [SHAMT_W-1:0]   shamt;
    logic                 enaf;
    logic [MAX_WIDTH-1:0] busA;
    logic [MAX_WIDTH-1:0] busB;
    logic [MAX_WIDTH-1:0] busC;
    logic [MAX_WIDTH-1:0] busC_hi;
    logic                 busy;
    logic                 done;
    logic                 C;
    logic                 N;
    logic                 P;
    logic                 Z;

    // Sequencer side: issues requests, consumes results and flags.
    modport master (
        output start, selop, shmode, shamt, enaf, busA, busB,
        input  busC, busC_hi, busy, done, C, N, P, Z
    );

    // ALU side.
    modport slave (
        input  start, selop, shmode, shamt, enaf, busA, busB,
        output busC, busC_hi, busy, done, C, N, P, Z
    );
endinterface

// File: rtl/pdua_alu_seq.sv
// Sequential PDUA ALU: single-cycle ops with post-shift, plus shift-add multiply.
// Latency: 1 cycle for single-cycle ops, MAX_WIDTH+1 cycles for multiply.
// Backpressure: start is ignored while busy (not queued); done pulses when results are valid.
module pdua_alu_seq #(
    parameter int MAX_WIDTH = 8,
    parameter int SHAMT_W   = 2,
    parameter bit MUL_EN    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    pdua_alu_seq_if.slave bus
);
    localparam int W      = MAX_WIDTH;
    localparam int CNT_W  = $clog2(MAX_WIDTH);
    localparam int SH_MAX = 1 << SHAMT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic             is_mul;
    logic             go_single;
    logic             go_mul;
    logic             mul_last;

    // Single-cycle datapath intermediates
    logic [W-1:0]     op_res;
    logic             op_c;
    logic [W-1:0]     sh_res;
    logic             sh_c;

    // Multiplier state: multiplicand shifts left, multiplier shifts right
    logic [2*W-1:0]   mcand_q;
    logic [W-1:0]     mplier_q;
    logic [2*W-1:0]   acc_q;
    logic [2*W-1:0]   step_sum;
    logic [CNT_W-1:0] cnt_q;
    logic             enaf_q;

    // Registered outputs
    logic [W-1:0]     busc_q;
    logic [W-1:0]     busc_hi_q;
    logic             done_q;
    logic             c_q;
    logic             n_q;
    logic             p_q;
    logic             z_q;

    // With the multiplier disabled, selop 111 falls through to pass-A
    assign is_mul = MUL_EN && (bus.selop == 3'b111);

    // Base operation; carry/borrow comes out of the extra MSB of the extended sum
    always_comb begin
        op_res = '0;
        op_c   = 1'b0;
        case (bus.selop)
            3'b000:  op_res = bus.busA;
            3'b001:  op_res = bus.busB;
            3'b010:  {op_c, op_res} = {1'b0, bus.busA} + {1'b0, bus.busB};
            3'b011:  {op_c, op_res} = {1'b0, bus.busA} - {1'b0, bus.busB};
            3'b100:  op_res = bus.busA & bus.busB;
            3'b101:  op_res = bus.busA | bus.busB;
            3'b110:  op_res = bus.busA ^ bus.busB;
            default: op_res = bus.busA;
        endcase
    end

    // Post-shift unrolled one bit per step so C tracks the last bit shifted out;
    // shamt=0 passes the base result and carry straight through
    always_comb begin
        sh_res = op_res;
        sh_c   = op_c;
        for (int i = 0; i < SH_MAX; i++) begin
            if (i < int'(bus.shamt)) begin
                case (bus.shmode)
                    2'b01: begin
                        sh_c   = sh_res[W-1];
                        sh_res = {sh_res[W-2:0], 1'b0};
                    end
                    2'b10: begin
                        sh_c   = sh_res[0];
                        sh_res = {1'b0, sh_res[W-1:1]};
                    end
                    2'b11: begin
                        sh_c   = sh_res[0];
                        sh_res = {sh_res[W-1], sh_res[W-1:1]};
                    end
                    default: begin
                        sh_c   = sh_c;
                        sh_res = sh_res;
                    end
                endcase
            end
        end
    end

    // One shift-add step: add the aligned multiplicand when the current multiplier bit is set
    assign step_sum = acc_q + (mplier_q[0] ? mcand_q : {2*W{1'b0}});

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and datapath control strobes
    always_comb begin
        state_d   = state_q;
        go_single = 1'b0;
        go_mul    = 1'b0;
        mul_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (is_mul) begin
                        go_mul  = 1'b1;
                        state_d = MUL;
                    end else begin
                        go_single = 1'b1;
                    end
                end
            end
            MUL: begin
                if (cnt_q == CNT_LAST) begin
                    mul_last = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath, result and flag registers; flags only move on a done cycle with enaf set
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            enaf_q    <= 1'b0;
            busc_q    <= '0;
            busc_hi_q <= '0;
            done_q    <= 1'b0;
            c_q       <= 1'b0;
            n_q       <= 1'b0;
            p_q       <= 1'b0;
            z_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (go_single) begin
                busc_q    <= sh_res;
                busc_hi_q <= '0;
                done_q    <= 1'b1;
                if (bus.enaf) begin
                    c_q <= sh_c;
                    n_q <= sh_res[W-1];
                    p_q <= ~^sh_res;
                    z_q <= (sh_res == '0);
                end
            end

            if (go_mul) begin
                mcand_q  <= {{W{1'b0}}, bus.busA};
                mplier_q <= bus.busB;
                acc_q    <= '0;
                cnt_q    <= '0;
                enaf_q   <= bus.enaf;
            end

            if (state_q == MUL) begin
                acc_q    <= step_sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CNT_W'(1);
                // Final step writes the product directly so done lands MAX_WIDTH+1 cycles after start
                if (mul_last) begin
                    busc_q    <= step_sum[W-1:0];
                    busc_hi_q <= step_sum[2*W-1:W];
                    done_q    <= 1'b1;
                    if (enaf_q) begin
                        c_q <= 1'b0;
                        n_q <= step_sum[2*W-1];
                        p_q <= ~^step_sum;
                        z_q <= (step_sum == '0);
                    end
                end
            end
        end
    end

    assign bus.busC    = busc_q;
    assign bus.busC_hi = busc_hi_q;
    assign bus.busy    = (state_q == MUL);
    assign bus.done    = done_q;
    assign bus.C       = c_q;
    assign bus.N       = n_q;
    assign bus.P       = p_q;
    assign bus.Z       = z_q;

endmodule

// File: tb/tb_pdua_alu_seq.sv
// Directed bench for pdua_alu_seq at MAX_WIDTH=8, SHAMT_W=2, MUL_EN=1.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Flags are compared packed as {C,N,P,Z}.
module tb_pdua_alu_seq;
    localparam int W  = 8;
    localparam int SW = 2;

    localparam logic [2:0] OP_A   = 3'b000;
    localparam logic [2:0] OP_B   = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pdua_alu_seq_if #(.MAX_WIDTH(W), .SHAMT_W(SW)) bus ();

    pdua_alu_seq #(.MAX_WIDTH(W), .SHAMT_W(SW), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.C, bus.N, bus.P, bus.Z};
    endfunction

    // Present one request at the falling edge, then step to just after the rising edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] sm, input logic [SW-1:0] sa,
                         input logic ef, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.selop  = op;
        bus.shmode = sm;
        bus.shamt  = sa;
        bus.enaf   = ef;
        bus.busA   = a;
        bus.busB   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        total = 0;
        bad   = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.selop  = OP_A;
        bus.shmode = 2'b00;
        bus.shamt  = '0;
        bus.enaf   = 1'b0;
        bus.busA   = '0;
        bus.busB   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busC", 16'(bus.busC), 16'h00);
        chk("rst_busC_hi", 16'(bus.busC_hi), 16'h00);
        chk("rst_busy_done", {14'b0, bus.busy, bus.done}, 16'h0);
        chk("rst_flags", 16'(flags()), 16'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1. ADD 7F+01
        issue(OP_ADD, 2'b00, 2'd0, 1'b1, 8'h7F, 8'h01);
        chk("add_busC", 16'(bus.busC), 16'h80);
        chk("add_done", 16'(bus.done), 16'h1);
        chk("add_flags", 16'(flags()), 16'b0100);
        idle_cycle();
        chk("add_done_pulse", 16'(bus.done), 16'h0);

        // 2. SUB 05-05, then 00-01 with flags frozen
        issue(OP_SUB, 2'b00, 2'd0, 1'b1, 8'h05, 8'h05);
        chk("sub0_busC", 16'(bus.busC), 16'h00);
        chk("sub0_flags", 16'(flags()), 16'b0011);
        issue(OP_SUB, 2'b00, 2'd0, 1'b0, 8'h00, 8'h01);
        chk("subb_busC", 16'(bus.busC), 16'hFF);
        chk("subb_flags_hold", 16'(flags()), 16'b0011);
        chk("subb_busC_hi", 16'(bus.busC_hi), 16'h00);

        // 3. Pass A with SRA 3, then SLL 1
        issue(OP_A, 2'b11, 2'd3, 1'b1, 8'h80, 8'h00);
        chk("sra_busC", 16'(bus.busC), 16'hF0);
        chk("sra_flags", 16'(flags()), 16'b0110);
        issue(OP_A, 2'b01, 2'd1, 1'b1, 8'h81, 8'h00);
        chk("sll_busC", 16'(bus.busC), 16'h02);
        chk("sll_flags", 16'(flags()), 16'b1000);
        // ADD 80+80 then SRL 1: result 00, C is the bit shifted out (0), not the add carry
        issue(OP_ADD, 2'b10, 2'd1, 1'b1, 8'h80, 8'h80);
        chk("srl_busC", 16'(bus.busC), 16'h00);
        chk("srl_flags", 16'(flags()), 16'b0011);
        idle_cycle();

        // 4. MUL FF*FF with an ignored start pulse in the middle
        issue(OP_MUL, 2'b00, 2'd0, 1'b1, 8'hFF, 8'hFF);
        chk("mul_busy_c1", {14'b0, bus.busy, bus.done}, 16'b10);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            bus.start = (k == 4);
            bus.selop = (k == 4) ? OP_ADD : OP_MUL;
            bus.busA  = (k == 4) ? 8'h00 : 8'hFF;
            bus.busB  = (k == 4) ? 8'h03 : 8'hFF;
            @(posedge clk);
            #1;
            chk($sformatf("mul_busy_c%0d", k), {14'b0, bus.busy, bus.done}, 16'b10);
        end
        idle_cycle();
        chk("mul_done_c9", {14'b0, bus.busy, bus.done}, 16'b01);
        chk("mul_product", {bus.busC_hi, bus.busC}, 16'hFE01);
        chk("mul_flags", 16'(flags()), 16'b0110);
        idle_cycle();
        chk("mul_done_pulse", 16'(bus.done), 16'h0);

        // Non-MUL op after MUL clears busC_hi; enaf=0 keeps the MUL flags
        issue(OP_ADD, 2'b00, 2'd0, 1'b0, 8'h01, 8'h02);
        chk("post_mul_busC", 16'(bus.busC), 16'h03);
        chk("post_mul_busC_hi", 16'(bus.busC_hi), 16'h00);
        chk("post_mul_flags", 16'(flags()), 16'b0110);
        idle_cycle();

        // 5. MUL 0F*11 aborted by reset on cycle 4
        issue(OP_MUL, 2'b00, 2'd0, 1'b1, 8'h0F, 8'h11);
        idle_cycle();
        idle_cycle();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy_done", {14'b0, bus.busy, bus.done}, 16'h0);
        chk("abort_busC", {bus.busC_hi, bus.busC}, 16'h0000);
        chk("abort_flags", 16'(flags()), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        chk("abort_no_done", 16'(done_seen), 16'h0);
        issue(OP_ADD, 2'b00, 2'd0, 1'b1, 8'h01, 8'h01);
        chk("after_abort_busC", 16'(bus.busC), 16'h02);
        chk("after_abort_flags", 16'(flags()), 16'b0000);

        // 6. start held high for four back-to-back ops
        issue(OP_AND, 2'b00, 2'd0, 1'b1, 8'hF0, 8'h3C);
        chk("b2b_and", {7'b0, bus.done, bus.busC}, 16'h130);
        issue(OP_OR, 2'b00, 2'd0, 1'b1, 8'hF0, 8'h3C);
        chk("b2b_or", {7'b0, bus.done, bus.busC}, 16'h1FC);
        issue(OP_XOR, 2'b00, 2'd0, 1'b1, 8'hF0, 8'h3C);
        chk("b2b_xor", {7'b0, bus.done, bus.busC}, 16'h1CC);
        issue(OP_B, 2'b00, 2'd0, 1'b1, 8'hF0, 8'h3C);
        chk("b2b_b", {7'b0, bus.done, bus.busC}, 16'h13C);
        chk("b2b_flags", 16'(flags()), 16'b0010);
        idle_cycle();
        chk("b2b_done_end", 16'(bus.done), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
